// File: rtl/data_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_collector_pkg
// Description : Shared types, default constants and helpers for the
//               multi-channel data collector.
//               - entry_width(): width of one stored {timestamp, data} entry
//               - chan_state_t : per-channel arm state
// Revision    : 1.0 - initial release
// ============================================================================
package data_collector_pkg;

  localparam int C_NB_DATA_COLLECTOR         = 1;
  localparam int C_DATA_COLLECTOR_DATA_WIDTH = 19;
  localparam int C_DEFAULT_DEPTH             = 16;
  localparam int C_DEFAULT_TS_WIDTH          = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } chan_state_t;

  // One FIFO entry is {timestamp, data}.
  function automatic int entry_width(input int ts_width, input int data_width);
    return ts_width + data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/collector_channel.sv
`default_nettype none
// ============================================================================
// Module      : collector_channel
// Description : One collector channel: arm/disarm FSM, change detector and a
//               FIFO of {timestamp, data} entries with registered head output.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               ts           - shared free-running timestamp
//               data         - watched vector
//               start / stop - arm / disarm pulses (stop wins when both high)
//               rd_en        - pop request (ignored while empty)
//               rd_data      - head entry {timestamp, data}, valid while !empty
//               empty / full - FIFO status
//               overflow     - sticky drop flag, cleared by rst or start
//               active       - channel armed
// Revision    : 1.0 - initial release
// ============================================================================
module collector_channel
  import data_collector_pkg::*;
#(
  parameter int G_DATA_WIDTH = C_DATA_COLLECTOR_DATA_WIDTH,
  parameter int G_DEPTH      = C_DEFAULT_DEPTH,
  parameter int G_TS_WIDTH   = C_DEFAULT_TS_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [G_TS_WIDTH-1:0]                           ts,
  input  logic [G_DATA_WIDTH-1:0]                         data,
  input  logic                                            start,
  input  logic                                            stop,
  input  logic                                            rd_en,
  output logic [entry_width(G_TS_WIDTH, G_DATA_WIDTH)-1:0] rd_data,
  output logic                                            empty,
  output logic                                            full,
  output logic                                            overflow,
  output logic                                            active
);

  localparam int ENTRY_W = entry_width(G_TS_WIDTH, G_DATA_WIDTH);
  localparam int PTR_W   = $clog2(G_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(G_DEPTH);

  chan_state_t               state;
  logic                      first_sample;
  logic [G_DATA_WIDTH-1:0]   last_data;
  logic                      ovf;

  logic [ENTRY_W-1:0]        mem [G_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [ENTRY_W-1:0]        head;

  logic                      is_empty;
  logic                      is_full;
  logic                      capture;
  logic                      pop;
  logic                      push;
  logic                      drop;
  logic [ENTRY_W-1:0]        wr_entry;
  logic [PTR_W-1:0]          rd_ptr_inc;

  always_comb begin
    is_empty   = (count == '0);
    is_full    = (count == DEPTH_CNT);
    // Nothing is sampled in the cycle that disarms the channel.
    capture    = (state == ST_ARMED) && !stop &&
                 (first_sample || (data != last_data));
    pop        = rd_en && !is_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = capture && (!is_full || pop);
    drop       = capture && is_full && !pop;
    wr_entry   = {ts, data};
    rd_ptr_inc = rd_ptr + PTR_W'(1);
  end

  // Arm FSM, change-detect reference and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      active       <= 1'b0;
      first_sample <= 1'b0;
      last_data    <= '0;
      ovf          <= 1'b0;
    end else begin
      first_sample <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state        <= ST_ARMED;
            active       <= 1'b1;
            first_sample <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state  <= ST_IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          active <= 1'b0;
        end
      endcase

      // Reference follows every sample, including dropped ones, so a
      // dropped value is not retried on the next cycle.
      if (capture) begin
        last_data <= data;
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (start) begin
        ovf <= 1'b0;
      end
    end
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy and registered head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end

      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      // Head tracks the entry that will sit at rd_ptr after this edge.
      // With two or more entries the successor is already in mem and is
      // never the slot being written this cycle.
      if (pop) begin
        if (count > CNT_W'(1)) begin
          head <= mem[rd_ptr_inc];
        end else if (push) begin
          head <= wr_entry;
        end
      end else if (is_empty && push) begin
        head <= wr_entry;
      end
    end
  end

  assign rd_data  = head;
  assign empty    = is_empty;
  assign full     = is_full;
  assign overflow = ovf;

endmodule
`default_nettype wire

// File: rtl/data_collector_core.sv
`default_nettype none
// ============================================================================
// Module      : data_collector_core
// Description : Multi-channel value-change collector. Each channel records
//               every change of its data vector with a shared cycle
//               timestamp into its own FIFO, drained through a read port.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               i_data      - channel k at [k*G_DATA_WIDTH +: G_DATA_WIDTH]
//               i_start     - per-channel arm pulse
//               i_stop      - per-channel disarm pulse
//               i_rd_en     - per-channel pop request
//               o_rd_data   - per-channel head {timestamp, data}
//               o_empty     - per-channel FIFO empty
//               o_full      - per-channel FIFO full
//               o_overflow  - per-channel sticky drop flag
//               o_active    - per-channel armed
// Revision    : 1.0 - initial release
// ============================================================================
module data_collector_core
  import data_collector_pkg::*;
#(
  parameter int G_NB_COLLECTOR = C_NB_DATA_COLLECTOR,
  parameter int G_DATA_WIDTH   = C_DATA_COLLECTOR_DATA_WIDTH,
  parameter int G_DEPTH        = C_DEFAULT_DEPTH,
  parameter int G_TS_WIDTH     = C_DEFAULT_TS_WIDTH
) (
  input  logic                                                           clk,
  input  logic                                                           rst,
  input  logic [G_NB_COLLECTOR*G_DATA_WIDTH-1:0]                         i_data,
  input  logic [G_NB_COLLECTOR-1:0]                                      i_start,
  input  logic [G_NB_COLLECTOR-1:0]                                      i_stop,
  input  logic [G_NB_COLLECTOR-1:0]                                      i_rd_en,
  output logic [G_NB_COLLECTOR*entry_width(G_TS_WIDTH, G_DATA_WIDTH)-1:0] o_rd_data,
  output logic [G_NB_COLLECTOR-1:0]                                      o_empty,
  output logic [G_NB_COLLECTOR-1:0]                                      o_full,
  output logic [G_NB_COLLECTOR-1:0]                                      o_overflow,
  output logic [G_NB_COLLECTOR-1:0]                                      o_active
);

  localparam int ENTRY_W = entry_width(G_TS_WIDTH, G_DATA_WIDTH);

  logic [G_TS_WIDTH-1:0] timestamp;

  // Shared free-running cycle counter; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      timestamp <= '0;
    end else begin
      timestamp <= timestamp + G_TS_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < G_NB_COLLECTOR; k++) begin : g_chan
    collector_channel #(
      .G_DATA_WIDTH (G_DATA_WIDTH),
      .G_DEPTH      (G_DEPTH),
      .G_TS_WIDTH   (G_TS_WIDTH)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .ts       (timestamp),
      .data     (i_data[k*G_DATA_WIDTH +: G_DATA_WIDTH]),
      .start    (i_start[k]),
      .stop     (i_stop[k]),
      .rd_en    (i_rd_en[k]),
      .rd_data  (o_rd_data[k*ENTRY_W +: ENTRY_W]),
      .empty    (o_empty[k]),
      .full     (o_full[k]),
      .overflow (o_overflow[k]),
      .active   (o_active[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_data_collector_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_collector_core
// Description : Directed self-checking bench for data_collector_core with
//               two channels; expected entries are queued as stimulus is
//               driven and compared as the FIFOs are drained.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_collector_core;

  localparam int NB    = 2;
  localparam int DW    = 19;
  localparam int DEPTH = 16;
  localparam int TSW   = 32;
  localparam int EW    = TSW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB*DW-1:0]  data;
  logic [NB-1:0]     start;
  logic [NB-1:0]     stop;
  logic [NB-1:0]     rd_en;
  logic [NB*EW-1:0]  rd_data;
  logic [NB-1:0]     empty;
  logic [NB-1:0]     full;
  logic [NB-1:0]     overflow;
  logic [NB-1:0]     active;

  int                compared   = 0;
  int                mismatched = 0;
  logic [TSW-1:0]    cyc;
  logic [TSW-1:0]    t0;
  logic [EW-1:0]     sb0[$];
  logic [EW-1:0]     sb1[$];
  logic [EW-1:0]     head_exp;

  data_collector_core #(
    .G_NB_COLLECTOR (NB),
    .G_DATA_WIDTH   (DW),
    .G_DEPTH        (DEPTH),
    .G_TS_WIDTH     (TSW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (data),
    .i_start    (start),
    .i_stop     (stop),
    .i_rd_en    (rd_en),
    .o_rd_data  (rd_data),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (overflow),
    .o_active   (active)
  );

  always #5 clk = ~clk;

  // Reference cycle count: equals the timestamp of the cycle in progress.
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    data[ch*DW +: DW] = v;
  endtask

  task automatic sb_push(input int ch, input logic [TSW-1:0] ts, input logic [DW-1:0] d);
    if (ch == 0) sb0.push_back({ts, d});
    else         sb1.push_back({ts, d});
  endtask

  task automatic drain(input int ch, input string tag);
    logic [EW-1:0] e;
    int n;
    n = (ch == 0) ? sb0.size() : sb1.size();
    for (int i = 0; i < n; i++) begin
      if (ch == 0) e = sb0.pop_front();
      else         e = sb1.pop_front();
      check({tag, "_not_empty"}, 64'(empty[ch]), 64'(0));
      check({tag, "_entry"}, 64'(rd_data[ch*EW +: EW]), 64'(e));
      rd_en[ch] = 1'b1;
      tick();
      rd_en[ch] = 1'b0;
    end
    check({tag, "_drained"}, 64'(empty[ch]), 64'(1));
  endtask

  initial begin
    rst   = 1'b1;
    data  = '0;
    start = '0;
    stop  = '0;
    rd_en = '0;
    ticks(3);
    rst = 1'b0;

    // Reset state
    check("rst_empty",    64'(empty),    64'(2'b11));
    check("rst_full",     64'(full),     64'(2'b00));
    check("rst_overflow", 64'(overflow), 64'(2'b00));
    check("rst_active",   64'(active),   64'(2'b00));
    check("rst_rd0",      64'(rd_data[0*EW +: EW]), 64'(0));
    check("rst_rd1",      64'(rd_data[1*EW +: EW]), 64'(0));

    // Idle: data toggles, nothing armed
    for (int i = 0; i < 100; i++) begin
      data = (NB*DW)'({$urandom(), $urandom()});
      tick();
    end
    check("idle_empty",    64'(empty),    64'(2'b11));
    check("idle_overflow", 64'(overflow), 64'(2'b00));
    check("idle_active",   64'(active),   64'(2'b00));

    // Basic capture on channel 1
    set_data(0, 19'h0);
    set_data(1, 19'h00000);
    t0 = cyc;
    start[1] = 1'b1;
    sb_push(1, t0 + 1, 19'h00000);
    tick();
    start[1] = 1'b0;
    check("basic_active", 64'(active[1]), 64'(1));
    ticks(4);
    set_data(1, 19'h4ABCD);
    sb_push(1, t0 + 5, 19'h4ABCD);
    ticks(5);
    stop[1] = 1'b1;
    set_data(1, 19'h11111);   // changes in the stop cycle are not recorded
    tick();
    stop[1] = 1'b0;
    check("basic_inactive", 64'(active[1]), 64'(0));
    ticks(2);
    check("basic_ch0_isolated", 64'(empty[0]), 64'(1));
    drain(1, "basic");

    // Constant data: single entry
    set_data(1, 19'h12345);
    t0 = cyc;
    start[1] = 1'b1;
    sb_push(1, t0 + 1, 19'h12345);
    tick();
    start[1] = 1'b0;
    ticks(49);
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    drain(1, "hold");

    // Overflow: 20 changes, first 16 retained
    set_data(1, 19'h100);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      set_data(1, 19'(19'h100 + k));
      if (k <= DEPTH) sb_push(1, cyc, 19'(19'h100 + k));
      tick();
    end
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    check("ovf_full",     64'(full[1]),     64'(1));
    check("ovf_flag",     64'(overflow[1]), 64'(1));
    check("ovf_ch0_flag", 64'(overflow[0]), 64'(0));

    // Re-arm clears overflow but keeps contents; then push+pop while full
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("rearm_ovf_clear", 64'(overflow[1]), 64'(0));
    check("rearm_keep_full", 64'(full[1]),     64'(1));
    set_data(1, 19'h2AAAA);
    head_exp = sb1.pop_front();
    check("pushpop_head", 64'(rd_data[1*EW +: EW]), 64'(head_exp));
    rd_en[1] = 1'b1;
    sb_push(1, cyc, 19'h2AAAA);
    tick();
    rd_en[1] = 1'b0;
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    check("pushpop_full", 64'(full[1]),     64'(1));
    check("pushpop_ovf",  64'(overflow[1]), 64'(0));
    drain(1, "wrap");

    // start and stop together: stop wins
    set_data(1, 19'h00003);
    start[1] = 1'b1;
    stop[1]  = 1'b1;
    tick();
    start[1] = 1'b0;
    stop[1]  = 1'b0;
    check("startstop_idle", 64'(active[1]), 64'(0));
    set_data(1, 19'h00005);
    ticks(3);
    check("startstop_empty", 64'(empty[1]), 64'(1));

    // Pop on an empty FIFO is ignored
    rd_en[1] = 1'b1;
    tick();
    rd_en[1] = 1'b0;
    check("rd_empty_empty", 64'(empty[1]), 64'(1));
    check("rd_empty_full",  64'(full[1]),  64'(0));

    // Channel 0 alone
    set_data(0, 19'h00007);
    t0 = cyc;
    start[0] = 1'b1;
    sb_push(0, t0 + 1, 19'h00007);
    tick();
    start[0] = 1'b0;
    ticks(2);
    check("ch0_has_entry", 64'(empty[0]), 64'(0));
    check("ch1_untouched", 64'(empty[1]), 64'(1));
    drain(0, "ch0");

    // Both channels busy, then reset mid-stream
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_data(0, 19'(19'h10 + i));
      set_data(1, 19'(19'h20 + i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_empty",    64'(empty),    64'(2'b11));
    check("midrst_active",   64'(active),   64'(2'b00));
    check("midrst_overflow", 64'(overflow), 64'(2'b00));
    check("midrst_full",     64'(full),     64'(2'b00));
    check("midrst_rd0",      64'(rd_data[0*EW +: EW]), 64'(0));
    check("midrst_rd1",      64'(rd_data[1*EW +: EW]), 64'(0));

    // Timestamp restarted from zero: first sample is stamped 1
    set_data(0, 19'h00055);
    start[0] = 1'b1;
    sb_push(0, 32'd1, 19'h00055);
    tick();
    start[0] = 1'b0;
    tick();
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    drain(0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
